// File: rtl/polar_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | polar_pkg                                                                  |
// | Shared types and constants for the polar rate-recovery stage.              |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package polar_pkg;

   localparam logic [2:0] N32  = 3'b010;
   localparam logic [2:0] N64  = 3'b011;
   localparam logic [2:0] N128 = 3'b100;
   localparam logic [2:0] N256 = 3'b101;
   localparam logic [2:0] N512 = 3'b110;

   // 38.212 sub-block interleaver pattern P(i)
   localparam logic [4:0] c_sb_pat [32] = '{
      5'd0,  5'd1,  5'd2,  5'd4,  5'd3,  5'd5,  5'd6,  5'd7,
      5'd8,  5'd16, 5'd9,  5'd17, 5'd10, 5'd18, 5'd11, 5'd19,
      5'd12, 5'd20, 5'd13, 5'd21, 5'd14, 5'd22, 5'd15, 5'd23,
      5'd24, 5'd25, 5'd26, 5'd28, 5'd27, 5'd29, 5'd30, 5'd31
   };

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INIT  = 3'd1,
      ST_FILL  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      REPETITION = 2'd0,
      PUNCTURE   = 2'd1,
      SHORTEN    = 2'd2
   } mode_t;

   // J(p) = P(p div S)*S + (p mod S), S = N/32 = 2**lsub
   function automatic logic [8:0] sb_addr(input logic [8:0] p, input logic [2:0] lsub);
      logic [4:0] idx;
      logic [8:0] lo_mask;
      logic [8:0] hi;
      idx     = 5'(p >> lsub);
      lo_mask = (9'd1 << lsub) - 9'd1;
      hi      = 9'(c_sb_pat[idx]) << lsub;
      return hi | (p & lo_mask);
   endfunction

endpackage
`default_nettype wire

// File: rtl/llr_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | llr_buf                                                                    |
// | 512-entry LLR store: one synchronous write port, one combinational read.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module llr_buf #(
   parameter int LLR_W = 8
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [8:0]       waddr_i,
   input  logic [LLR_W-1:0] wdata_i,
   input  logic [8:0]       raddr_i,
   output logic [LLR_W-1:0] rdata_o
);

   logic [LLR_W-1:0] r_mem [512];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         r_mem[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = r_mem[raddr_i];

endmodule
`default_nettype wire

// File: rtl/rate_recover.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rate_recover                                                               |
// | Polar de-rate-matching: E channel LLRs -> N mother-code LLRs, natural      |
// | order. RATE_RECOVER_REPETITION_EN enables soft-combining of repeats.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module rate_recover
   import polar_pkg::*;
#(
   parameter int LLR_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [8:0]       K_i,
   input  logic [14:0]      E_i,
   input  logic [2:0]       N_i,
   input  logic             llr_valid_i,
   input  logic [LLR_W-1:0] llr_i,
   output logic             llr_ready_o,
   output logic             out_valid_o,
   output logic [LLR_W-1:0] out_llr_o,
   output logic [8:0]       out_idx_o,
   input  logic             out_ready_i,
   output logic             busy_o,
   output logic             done_o
);

   localparam logic [LLR_W-1:0] c_llr_max = {1'b0, {(LLR_W-1){1'b1}}};

   state_t           r_state, w_next;
   mode_t            r_mode;
   logic [8:0]       r_nm1, r_cnt, r_p;
   logic [2:0]       r_lsub;
   logic [14:0]      r_elast, r_k;
   logic             r_first, r_rd_last;
   logic             r_out_valid;
   logic [LLR_W-1:0] r_out_llr;
   logic [8:0]       r_out_idx;

   logic             w_legal, w_rep, w_punc, w_fire;
   logic             w_init_end, w_fill_end, w_load, w_drain_end;
   logic [8:0]       w_nm1, w_j, w_waddr, w_raddr;
   logic [18:0]      w_k16, w_e7;
   logic [LLR_W-1:0] w_rdata, w_wdata, w_fill, w_acc;
   logic             w_we, w_acc_en;

   // Start-time decode of N, and mode selection from the 19-bit products
   assign w_legal = (N_i >= N32) && (N_i <= N512);
   assign w_nm1   = 9'h1FF >> (3'd6 - N_i);
   assign w_rep   = (15'(w_nm1) < E_i);
   assign w_k16   = 19'(K_i) << 4;
   assign w_e7    = (19'(E_i) << 3) - 19'(E_i);
   assign w_punc  = (w_k16 <= w_e7);

   assign w_fire      = (r_state == ST_FILL) && llr_valid_i;
   assign w_init_end  = (r_state == ST_INIT) && (r_cnt == r_nm1);
   assign w_fill_end  = w_fire && (r_k == r_elast);
   assign w_load      = (r_state == ST_DRAIN) && !r_rd_last && (!r_out_valid || out_ready_i);
   assign w_drain_end = (r_state == ST_DRAIN) && r_rd_last && r_out_valid && out_ready_i;

   assign w_j = sb_addr(r_p, r_lsub);

`ifdef RATE_RECOVER_REPETITION_EN
   localparam logic signed [LLR_W:0] c_sum_max = {2'b00, {(LLR_W-1){1'b1}}};
   localparam logic signed [LLR_W:0] c_sum_min = {2'b11, {(LLR_W-2){1'b0}}, 1'b1};
   logic signed [LLR_W:0] w_sum;

   assign w_sum    = {w_rdata[LLR_W-1], w_rdata} + {llr_i[LLR_W-1], llr_i};
   assign w_acc_en = 1'b1;

   always_comb begin
      w_acc = w_sum[LLR_W-1:0];
      if (w_sum > c_sum_max) begin
         w_acc = c_sum_max[LLR_W-1:0];
      end else if (w_sum < c_sum_min) begin
         w_acc = c_sum_min[LLR_W-1:0];
      end
   end
`else
   assign w_acc    = llr_i;
   assign w_acc_en = 1'b0;
`endif

   assign w_fill  = (r_mode == SHORTEN) ? c_llr_max : '0;
   assign w_we    = (r_state == ST_INIT) || (w_fire && (r_first || w_acc_en));
   assign w_waddr = (r_state == ST_INIT) ? r_cnt : w_j;
   assign w_wdata = (r_state == ST_INIT) ? w_fill : (r_first ? llr_i : w_acc);
   assign w_raddr = (r_state == ST_DRAIN) ? r_cnt : w_j;

   llr_buf #(
      .LLR_W   (LLR_W)
   ) u_buf (
      .clk_i   (clk_i),
      .we_i    (w_we),
      .waddr_i (w_waddr),
      .wdata_i (w_wdata),
      .raddr_i (w_raddr),
      .rdata_o (w_rdata)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (start_i && w_legal) w_next = ST_INIT;
         ST_INIT:  if (w_init_end)         w_next = ST_FILL;
         ST_FILL:  if (w_fill_end)         w_next = ST_DRAIN;
         ST_DRAIN: if (w_drain_end)        w_next = ST_DONE;
         ST_DONE:                          w_next = ST_IDLE;
         default:                          w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      llr_ready_o = (r_state == ST_FILL);
      busy_o      = (r_state != ST_IDLE);
      done_o      = (r_state == ST_DONE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_mode      <= REPETITION;
         r_nm1       <= '0;
         r_lsub      <= '0;
         r_elast     <= '0;
         r_cnt       <= '0;
         r_p         <= '0;
         r_k         <= '0;
         r_first     <= 1'b0;
         r_rd_last   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_llr   <= '0;
         r_out_idx   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (start_i && w_legal) begin
                  r_nm1   <= w_nm1;
                  r_lsub  <= N_i - 3'd2;
                  r_elast <= E_i - 15'd1;
                  r_mode  <= w_rep ? REPETITION : (w_punc ? PUNCTURE : SHORTEN);
               end
            end
            ST_INIT: begin
               r_cnt <= r_cnt + 9'd1;
               if (w_init_end) begin
                  r_k     <= '0;
                  r_first <= 1'b1;
                  // puncturing skips the first N-E y-positions
                  r_p     <= (r_mode == PUNCTURE) ? (r_nm1 - r_elast[8:0]) : '0;
               end
            end
            ST_FILL: begin
               if (w_fire) begin
                  r_k <= r_k + 15'd1;
                  if (r_p == r_nm1) begin
                     r_p     <= '0;
                     r_first <= 1'b0;
                  end else begin
                     r_p <= r_p + 9'd1;
                  end
               end
               if (w_fill_end) begin
                  r_cnt     <= '0;
                  r_rd_last <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (w_load) begin
                  r_out_llr   <= w_rdata;
                  r_out_idx   <= r_cnt;
                  r_out_valid <= 1'b1;
                  r_cnt       <= r_cnt + 9'd1;
                  if (r_cnt == r_nm1) begin
                     r_rd_last <= 1'b1;
                  end
               end else if (r_out_valid && out_ready_i) begin
                  r_out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_valid_o = r_out_valid;
   assign out_llr_o   = r_out_llr;
   assign out_idx_o   = r_out_idx;

endmodule
`default_nettype wire

// File: tb/tb_rate_recover.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rate_recover                                                            |
// | Directed bench with a spec-level de-rate-matching model and a scoreboard.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_rate_recover;

`ifdef RATE_RECOVER_REPETITION_EN
   localparam bit MAC = 1'b1;
`else
   localparam bit MAC = 1'b0;
`endif
   localparam int MAXV = 127;

   logic       clk, rst_n, start_i, llr_valid_i, out_ready;
   logic [8:0] K_i;
   logic [14:0] E_i;
   logic [2:0] N_i;
   logic [7:0] llr_i;
   logic       llr_ready_o, out_valid_o, busy_o, done_o;
   logic [7:0] out_llr_o;
   logic [8:0] out_idx_o;

   rate_recover #(.LLR_W(8)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start_i),
      .K_i         (K_i),
      .E_i         (E_i),
      .N_i         (N_i),
      .llr_valid_i (llr_valid_i),
      .llr_i       (llr_i),
      .llr_ready_o (llr_ready_o),
      .out_valid_o (out_valid_o),
      .out_llr_o   (out_llr_o),
      .out_idx_o   (out_idx_o),
      .out_ready_i (out_ready),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   int n_checks = 0, n_fail = 0;
   int cyc = 0, s_cyc = 0;
   int src [8192];
   int expd [512];
   int got [512];
   int pat [32] = '{0,1,2,4,3,5,6,7,8,16,9,17,10,18,11,19,
                    12,20,13,21,14,22,15,23,24,25,26,28,27,29,30,31};
   int exp_n = 0, exp_e = 0, nxt = 0, done_cnt = 0;
   bit active = 0, chk_lat = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   function automatic int sat(input int v);
      return (v > MAXV) ? MAXV : ((v < -MAXV) ? -MAXV : v);
   endfunction

   // Straight from the bit-selection rules: build y[], then scatter through J.
   task automatic build_model(input int ncode, input int kk, input int ee);
      int n, s, p;
      bit rep, punc;
      int y [512];
      n = 1 << (ncode + 3);
      s = n / 32;
      rep  = (ee >= n);
      punc = !rep && (kk * 16 <= ee * 7);
      for (int i = 0; i < n; i++) y[i] = (!rep && !punc) ? MAXV : 0;
      for (int k = 0; k < ee; k++) begin
         p = rep ? (k % n) : (punc ? k + n - ee : k);
         if (k < n) y[p] = src[k];
         else if (MAC) y[p] = sat(y[p] + src[k]);
      end
      for (int i = 0; i < n; i++) expd[pat[i / s] * s + (i % s)] = y[i];
      exp_n = n;
   endtask

   // Single compare process: scoreboard of every output transfer and stall.
   initial begin
      bit   prev_stall;
      int   prev_idx, prev_llr, v;
      prev_stall = 0; prev_idx = 0; prev_llr = 0;
      forever begin
         @(negedge clk);
         if (active) begin
            v = $signed(out_llr_o);
            if (prev_stall) begin
               check("hold_valid", int'(out_valid_o), 1);
               check("hold_idx", int'(out_idx_o), prev_idx);
               check("hold_llr", v, prev_llr);
            end
            if (out_valid_o && out_ready) begin
               check("out_idx", int'(out_idx_o), nxt);
               check("out_llr", v, expd[out_idx_o]);
               got[out_idx_o] = v;
               nxt++;
            end
            prev_stall = out_valid_o && !out_ready;
            prev_idx   = int'(out_idx_o);
            prev_llr   = v;
            if (done_o) begin
               done_cnt++;
               check("outputs_before_done", nxt, exp_n);
               if (chk_lat) check("latency", cyc - s_cyc, 2 * exp_n + exp_e + 2);
            end
         end else begin
            prev_stall = 0;
         end
      end
   end

   task automatic run_cw(input int ncode, input int kk, input int ee,
                         input bit bp, input bit gaps, input bit stray, input bit lat);
      int k, guard, rdy_gap;
      bit rdy_seen, got_done;
      build_model(ncode, kk, ee);
      for (int i = 0; i < 512; i++) got[i] = -999;
      nxt = 0; done_cnt = 0; chk_lat = lat; exp_e = ee; active = 1;
      @(negedge clk);
      start_i = 1'b1; N_i = 3'(ncode); K_i = 9'(kk); E_i = 15'(ee);
      llr_valid_i = 1'b1; llr_i = 8'(src[0]); s_cyc = cyc;
      k = 0; guard = 0; rdy_gap = 0; rdy_seen = 0;
      while (k < ee && guard < 20000) begin
         @(negedge clk);
         guard++;
         start_i = stray && (k == 5);
         if (stray) N_i = 3'b110;
         llr_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         llr_i = 8'(src[k]);
         if (llr_ready_o) rdy_seen = 1;
         else if (rdy_seen) rdy_gap++;
         if (llr_valid_i && llr_ready_o) k++;
      end
      check("fill_beats", k, ee);
      check("ready_gap", rdy_gap, 0);
      @(negedge clk);
      llr_valid_i = 1'b0; start_i = 1'b0;
      check("ready_drop", int'(llr_ready_o), 0);
      got_done = 0; guard = 0;
      while (!got_done && guard < 5000) begin
         @(posedge clk);
         #1;
         out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         guard++;
         @(negedge clk);
         if (done_o) got_done = 1;
      end
      check("done_seen", int'(got_done), 1);
      @(posedge clk);
      #1 out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("done_once", done_cnt, 1);
      check("idle_after", int'(busy_o), 0);
      active = 0;
   endtask

   initial begin
      rst_n = 1'b0; start_i = 0; K_i = 0; E_i = 0; N_i = 0;
      llr_valid_i = 0; llr_i = 0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ready", int'(llr_ready_o), 0);
      check("rst_valid", int'(out_valid_o), 0);
      check("rst_llr", int'(out_llr_o), 0);
      check("rst_idx", int'(out_idx_o), 0);
      check("rst_busy", int'(busy_o), 0);
      check("rst_done", int'(done_o), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // illegal N codes leave the block idle
      start_i = 1'b1; N_i = 3'b000; K_i = 9'd20; E_i = 15'd30;
      @(negedge clk); start_i = 1'b0;
      repeat (2) @(negedge clk);
      check("illegal_000_busy", int'(busy_o), 0);
      start_i = 1'b1; N_i = 3'b111;
      @(negedge clk); start_i = 1'b0;
      @(negedge clk);
      check("illegal_111_busy", int'(busy_o), 0);

      // shorten
      for (int k = 0; k < 30; k++) src[k] = k + 1;
      run_cw(2, 20, 30, 0, 0, 0, 1);
      check("short_d30", got[30], 127);
      check("short_d31", got[31], 127);
      check("short_d0", got[0], 1);
      check("short_d3", got[3], 5);
      check("short_d4", got[4], 4);

      // puncture, with input gaps and a stray start mid-FILL
      for (int k = 0; k < 48; k++) src[k] = k + 1;
      run_cw(3, 18, 48, 0, 1, 1, 0);
      check("punc_d0", got[0], 0);
      check("punc_d15", got[15], 0);
      check("punc_d16", got[16], 1);
      check("punc_d17", got[17], 2);
      check("punc_d32", got[32], 3);

      // repetition
      for (int k = 0; k < 40; k++) src[k] = 100;
      run_cw(2, 20, 40, 0, 0, 0, 1);
      check("rep_d0", got[0], MAC ? 127 : 100);
      check("rep_d7", got[7], MAC ? 127 : 100);
      check("rep_d8", got[8], 100);
      check("rep_d31", got[31], 100);
      for (int k = 0; k < 40; k++) src[k] = -25;
      run_cw(2, 20, 40, 0, 0, 0, 1);
      check("repn_d0", got[0], MAC ? -50 : -25);
      check("repn_d9", got[9], -25);

      // reset mid-FILL aborts
      @(negedge clk);
      start_i = 1'b1; N_i = 3'b011; K_i = 9'd18; E_i = 15'd100;
      llr_valid_i = 1'b1; llr_i = 8'd7;
      @(negedge clk); start_i = 1'b0;
      repeat (70) @(negedge clk);
      check("pre_reset_fill", int'(llr_ready_o), 1);
      rst_n = 1'b0;
      #1;
      check("abort_ready", int'(llr_ready_o), 0);
      check("abort_valid", int'(out_valid_o), 0);
      check("abort_llr", int'(out_llr_o), 0);
      check("abort_idx", int'(out_idx_o), 0);
      check("abort_busy", int'(busy_o), 0);
      check("abort_done", int'(done_o), 0);
      @(negedge clk);
      rst_n = 1'b1; llr_valid_i = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 30; k++) src[k] = 3 * k - 40;
      run_cw(2, 20, 30, 0, 0, 0, 1);

      // N=512 repetition with random downstream backpressure
      for (int k = 0; k < 600; k++) src[k] = ((k * 37) % 255) - 127;
      run_cw(6, 140, 600, 1, 0, 0, 0);
      check("bp_count", nxt, 512);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rate_recover.md
# rate_recover

Rate-recovery stage of the polar decoder: de-rate-matches one received codeword of E channel LLRs into the N-entry mother-code LLR vector consumed by the SC decoder core. It sits downstream of the mother-code-length calculation and takes that block's 3-bit N code directly. For each codeword it:
- applies the 38.212 bit-selection inverse (repetition, puncturing or shortening);
- undoes the 32-sub-block interleaver;
- streams the N recovered LLRs out in natural order.

## Interface
Parameters:
- LLR_W, 8, signed LLR width; saturation bounds are ±(2^(LLR_W-1)-1).

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  reset; asynchronous, active-low.
- start_i  in  1  one-cycle pulse; captures K_i/E_i/N_i. Accepted only in IDLE.
- K_i  in  9  info bits incl. CRC, 18..140.
- E_i  in  15  rate-matched length, 18..8192.
- N_i  in  3  mother-code length code: 010=32, 011=64, 100=128, 101=256, 110=512.
- llr_valid_i  in  1  input LLR valid.
- llr_i  in  LLR_W  input LLR, signed, e_k order.
- llr_ready_o  in/out: out  1  input ready; high only in FILL.
- out_valid_o  out  1  output LLR valid.
- out_llr_o  out  LLR_W  recovered LLR d_n.
- out_idx_o  out  9  n, 0..N-1.
- out_ready_i  in  1  downstream ready.
- busy_o  out  1  high outside IDLE.
- done_o  out  1  one-cycle pulse after the last output transfer.

## Operation
- States and transitions:
  - IDLE → INIT on start_i with a legal N_i. Illegal code: start_i ignored, block stays IDLE.
  - INIT: writes fill value to all N buffer entries, one per cycle.
  - FILL: accepts E LLRs.
  - DRAIN: emits N LLRs.
  - DONE: one cycle with done_o=1, then → IDLE.
- Mode, decided at start:
  - repetition if E≥N;
  - else puncture if K·16 ≤ E·7;
  - else shorten.
  - Products are unsigned, 19 bits wide.
- INIT fill value:
  - repetition: 0;
  - puncture: 0;
  - shorten: +max.
- FILL, for input k (0..E-1), y-position p is:
  - repetition: k mod N, via a wrapping counter; no divider.
  - puncture: k+N−E.
  - shorten: k.
- Buffer address is J(p) = P(i)·(N/32) + (p mod N/32), with i = p div (N/32).
  - P is the 38.212 sub-block interleaver pattern: 0,1,2,4,3,5,6,7,8,16,9,17,10,18,11,19,12,20,13,21,14,22,15,23,24,25,26,28,27,29,30,31.
- Write rule:
  - plain write in puncture and shorten modes;
  - in repetition mode the first pass (k<N) writes; later passes per Configuration.
- DRAIN: reads n=0..N-1. out_idx_o=n, out_llr_o=buf[n].
- start_i outside IDLE is ignored. Input beats while llr_ready_o=0 are not consumed.

## Timing
- Reset values, all outputs 0: llr_ready_o, out_valid_o, out_llr_o, out_idx_o, busy_o, done_o. State returns to IDLE. Buffer contents are don't-care.
- Reset asserted mid-operation aborts immediately. Partial data is discarded and no done_o is produced.
- start_i to first INIT write: 1 cycle. INIT takes exactly N cycles.
- FILL: one transfer per cycle when llr_valid_i && llr_ready_o.
  - Repetition read-modify-write completes in the same cycle, so there are no stalls: llr_ready_o stays high throughout FILL.
  - llr_ready_o drops in the cycle after the E-th transfer.
- DRAIN: out_valid_o rises the cycle after FILL ends.
  - Registered output; out_llr_o/out_idx_o are held stable while out_valid_o && !out_ready_i.
  - Zero-bubble: N transfers in N cycles when out_ready_i=1.
- done_o pulses the cycle after the N-th output transfer. Next start_i is accepted the following cycle.
- Best-case latency from start_i to done_o: 1 + N + E + N + 1 cycles.

## Configuration
- RATE_RECOVER_REPETITION_EN defined:
  - For k≥N, the new LLR is added to the stored value with saturation to ±(2^(LLR_W-1)-1).
  - The adder is LLR_W+1 bits wide, then clamped.
- Undefined:
  - For k≥N, beats are still accepted and consumed (llr_ready_o high) but discarded. The buffer holds the first copy only.
  - No adder is built.

## Structure
- Package polar_pkg holds:
  - N-code localparams (N32..N512);
  - the 32-entry sub-block pattern constant P;
  - the state enum typedef;
  - the mode enum (REPETITION, PUNCTURE, SHORTEN).
- One sub-module: llr_buf.
  - 512×LLR_W storage.
  - One write port and one combinational read port.
  - Shared by the FILL read-modify-write and DRAIN.

## Test plan
- Shorten: N=010, K=20, E=30, llr_i=k+1.
  - d0..d29 = 1..30 in J-permuted positions.
  - d30 = d31 = +127, since P(30)=30 and P(31)=31.
- Puncture: N=011, K=18, E=48.
  - d0..d15 = 0.
  - Input k lands at J(k+16), e.g. k=0 → d16.
  - 48 inputs and 64 outputs, done_o once.
- Repetition with macro: N=010, E=40, every llr_i=100.
  - y0..y7 saturate to +127; others are 100.
  - With -25 inputs, the overlapped entries give -50.
- Repetition without macro: same stimulus.
  - All outputs 100.
  - llr_ready_o stays high for 40 transfers.
- Backpressure: out_ready_i toggled randomly during DRAIN with N=110.
  - Outputs stay stable while stalled.
  - Indices appear as 0..511 exactly once.
- Reset/illegal input:
  - rst_ni low mid-FILL → all outputs 0, IDLE; a new start then completes normally.
  - start_i with N_i=000 → busy_o stays 0.
